// File: rtl/timer_tick_sequencer.sv
// timer_tick_sequencer
//
// Avalon-MM write-only master for a 16-bit interval timer slave (s1 port, no
// waitrequest, single-cycle writes). Programs a 64-bit period, starts the
// timer in continuous mode with interrupt enabled, acknowledges each timeout
// and emits one single-cycle tick per acknowledged timeout.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   cfg_valid/cfg_ready  period request handshake (accept when both high)
//   cfg_period           requested load value, clamped to a minimum of 4
//   stop_req             level request to stop the timer and go idle
//   tmr_irq              timer interrupt (level)
//   tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata  timer s1 writes
//   tick                 one-cycle pulse, coincides with the status ack write
//   running              timer started and not stopped
//   busy                 programming or stopping sequence in progress
//   tick_count           ticks since last cfg accept
//
// Configuration macro: TIMER_SEQ_TICK_COUNT_EN builds the tick counter;
// without it tick_count is tied to zero.

`timescale 1ns/1ps

module timer_tick_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [63:0] cfg_period,
   input  logic        stop_req,
   input  logic        tmr_irq,
   output logic [3:0]  tmr_address,
   output logic        tmr_chipselect,
   output logic        tmr_write_n,
   output logic [15:0] tmr_writedata,
   output logic        tick,
   output logic        running,
   output logic        busy,
   output logic [31:0] tick_count
);

   typedef enum logic [3:0] {
      StIdle, StStop, StClr, StP0, StP1, StP2, StP3, StStart,
      StRun, StAck, StWait, StHStop, StHClr
   } state_e;

   localparam logic [3:0]  AddrStatus = 4'd0;
   localparam logic [3:0]  AddrCtrl   = 4'd1;
   localparam logic [15:0] CtrlStop   = 16'h0008;
   localparam logic [15:0] CtrlStart  = 16'h0007;  // ITO | CONT | START

   state_e      state_q, state_d;
   logic [63:0] load_q;
   logic        cfg_accept;
   logic        wr_en_d;
   logic [3:0]  wr_addr_d;
   logic [15:0] wr_data_d;
   logic        busy_d;

   always_comb begin
      cfg_ready = ((state_q == StIdle) || (state_q == StRun)) && !tmr_irq && !stop_req;
   end

   assign cfg_accept = cfg_valid && cfg_ready;

   // Next state. In RUN a pending timeout always wins; cfg_ready already
   // excludes irq and stop, so stop beats reprogram.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (cfg_accept) state_d = StStop;
         StStop:  state_d = StClr;
         StClr:   state_d = StP0;
         StP0:    state_d = StP1;
         StP1:    state_d = StP2;
         StP2:    state_d = StP3;
         StP3:    state_d = StStart;
         StStart: state_d = StRun;
         StRun: begin
            if (tmr_irq)         state_d = StAck;
            else if (stop_req)   state_d = StHStop;
            else if (cfg_accept) state_d = StStop;
         end
         StAck:   state_d = StWait;
         StWait:  state_d = StRun;
         StHStop: state_d = StHClr;
         StHClr:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Write decode for the state being entered, so the bus outputs can be
   // registered and still line up with the state they belong to.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = 4'd0;
      wr_data_d = 16'h0000;
      busy_d    = 1'b0;
      case (state_d)
         StStop:  begin wr_en_d = 1'b1; wr_addr_d = AddrCtrl;   wr_data_d = CtrlStop;      busy_d = 1'b1; end
         StClr:   begin wr_en_d = 1'b1; wr_addr_d = AddrStatus;                            busy_d = 1'b1; end
         StP0:    begin wr_en_d = 1'b1; wr_addr_d = 4'd2;       wr_data_d = load_q[15:0];  busy_d = 1'b1; end
         StP1:    begin wr_en_d = 1'b1; wr_addr_d = 4'd3;       wr_data_d = load_q[31:16]; busy_d = 1'b1; end
         StP2:    begin wr_en_d = 1'b1; wr_addr_d = 4'd4;       wr_data_d = load_q[47:32]; busy_d = 1'b1; end
         StP3:    begin wr_en_d = 1'b1; wr_addr_d = 4'd5;       wr_data_d = load_q[63:48]; busy_d = 1'b1; end
         StStart: begin wr_en_d = 1'b1; wr_addr_d = AddrCtrl;   wr_data_d = CtrlStart;     busy_d = 1'b1; end
         StAck:   begin wr_en_d = 1'b1; wr_addr_d = AddrStatus; end
         StHStop: begin wr_en_d = 1'b1; wr_addr_d = AddrCtrl;   wr_data_d = CtrlStop;      busy_d = 1'b1; end
         StHClr:  begin wr_en_d = 1'b1; wr_addr_d = AddrStatus;                            busy_d = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         load_q         <= 64'd0;
         tmr_address    <= 4'd0;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_writedata  <= 16'h0000;
         tick           <= 1'b0;
         running        <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_address    <= wr_addr_d;
         tmr_chipselect <= wr_en_d;
         tmr_write_n    <= !wr_en_d;
         tmr_writedata  <= wr_data_d;
         tick           <= (state_d == StAck);
         busy           <= busy_d;
         // Minimum load of 4 keeps the ACK/WAIT window shorter than a period.
         if (cfg_accept) begin
            load_q <= (cfg_period < 64'd4) ? 64'd4 : cfg_period;
         end
         if ((state_d == StStop) || (state_d == StHStop)) begin
            running <= 1'b0;
         end else if (state_q == StStart) begin
            running <= 1'b1;
         end
      end
   end

`ifdef TIMER_SEQ_TICK_COUNT_EN
   logic [31:0] tick_count_q;

   // Accept and ACK are mutually exclusive (accept needs irq low).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_count_q <= 32'd0;
      end else if (cfg_accept) begin
         tick_count_q <= 32'd0;
      end else if (state_d == StAck) begin
         tick_count_q <= tick_count_q + 32'd1;
      end
   end

   assign tick_count = tick_count_q;
`else
   assign tick_count = 32'd0;
`endif

endmodule

// File: tb/tb_timer_tick_sequencer.sv
`timescale 1ns/1ps

module tb_timer_tick_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [63:0] cfg_period = 64'd0;
   logic        stop_req = 1'b0;
   logic        tmr_irq;
   logic [3:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic        tick;
   logic        running;
   logic        busy;
   logic [31:0] tick_count;

   timer_tick_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_period     (cfg_period),
      .stop_req       (stop_req),
      .tmr_irq        (tmr_irq),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tick           (tick),
      .running        (running),
      .busy           (busy),
      .tick_count     (tick_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Interval timer slave model: continuous countdown, TO set when the
   // counter passes zero (set wins over a same-edge status clear).
   logic [63:0] per_q, cnt_q;
   logic        run_q, to_q, ito_q;
   assign tmr_irq = to_q & ito_q;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         per_q <= 64'd0; cnt_q <= 64'd0; run_q <= 1'b0; to_q <= 1'b0; ito_q <= 1'b0;
      end else begin
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               4'd0: to_q <= 1'b0;
               4'd1: begin
                  ito_q <= tmr_writedata[0];
                  if (tmr_writedata[3]) run_q <= 1'b0;
                  else if (tmr_writedata[2]) begin run_q <= 1'b1; cnt_q <= per_q; end
               end
               4'd2: per_q[15:0]  <= tmr_writedata;
               4'd3: per_q[31:16] <= tmr_writedata;
               4'd4: per_q[47:32] <= tmr_writedata;
               4'd5: per_q[63:48] <= tmr_writedata;
               default: ;
            endcase
         end
         if (run_q) begin
            if (cnt_q == 64'd0) begin to_q <= 1'b1; cnt_q <= per_q; end
            else cnt_q <= cnt_q - 64'd1;
         end
      end
   end

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      bit          tk;
      int          tc;
      int          at;   // expected cycle, -1 = any
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad = 0;

   function automatic void chk(input bit ok, input string name,
                               input logic [63:0] act, input logic [63:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic int exp_tc(input int i);
`ifdef TIMER_SEQ_TICK_COUNT_EN
      return i;
`else
      return 0 * i;
`endif
   endfunction

   task automatic push(input logic [3:0] a, input logic [15:0] d, input bit tk,
                       input int tc, input int at);
      wr_t e;
      e.addr = a; e.data = d; e.tk = tk; e.tc = tc; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic push_prog(input logic [63:0] ld, input int acc);
      push(4'd1, 16'h0008, 1'b0, 0, acc);
      push(4'd0, 16'h0000, 1'b0, 0, acc + 1);
      push(4'd2, ld[15:0], 1'b0, 0, acc + 2);
      push(4'd3, ld[31:16], 1'b0, 0, acc + 3);
      push(4'd4, ld[47:32], 1'b0, 0, acc + 4);
      push(4'd5, ld[63:48], 1'b0, 0, acc + 5);
      push(4'd1, 16'h0007, 1'b0, 0, acc + 6);
   endtask

   // Tick i lands load+9 edges after accept, then every load+1.
   task automatic push_ticks(input int acc, input int ld, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         push(4'd0, 16'h0000, 1'b1, exp_tc(i), acc + ld + 9 + (i - 1) * (ld + 1));
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (tmr_chipselect && !tmr_write_n) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_write", 64'({tick, tmr_address, tmr_writedata}), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk({tick, tmr_address, tmr_writedata} == {e.tk, e.addr, e.data}, "write",
                      64'({tick, tmr_address, tmr_writedata}), 64'({e.tk, e.addr, e.data}));
                  if (e.at >= 0) chk(cyc == e.at, "write_cycle", 64'(cyc), 64'(e.at));
                  if (e.tk) chk(tick_count == 32'(e.tc), "tick_count", 64'(tick_count), 64'(e.tc));
               end
            end else if (tick) begin
               chk(1'b0, "tick_without_write", 64'(tick), 64'd0);
            end
         end
      end
   endtask

   task automatic wait_empty(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      chk(exp_q.size() == 0, name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic goto_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic accept(input logic [63:0] p, output int acc);
      int n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(cfg_ready == 1'b1, "cfg_ready_wait", 64'(cfg_ready), 64'd1);
      cfg_period = p;
      cfg_valid  = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      cfg_valid = 1'b0;
   endtask

   // busy during the seven write cycles, running from the eighth.
   task automatic prog_timing();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk(busy == (k <= 6), "prog_busy", 64'(busy), 64'(k <= 6));
         chk(running == (k == 7), "prog_running", 64'(running), 64'(k == 7));
      end
   endtask

   task automatic check_idle(input string name);
      chk(busy == 1'b0, {name, "_busy"}, 64'(busy), 64'd0);
      chk(running == 1'b0, {name, "_running"}, 64'(running), 64'd0);
   endtask

   task automatic check_reset_outputs();
      chk(tmr_address == 4'd0, "rst_addr", 64'(tmr_address), 64'd0);
      chk(tmr_chipselect == 1'b0, "rst_cs", 64'(tmr_chipselect), 64'd0);
      chk(tmr_write_n == 1'b1, "rst_write_n", 64'(tmr_write_n), 64'd1);
      chk(tmr_writedata == 16'h0000, "rst_data", 64'(tmr_writedata), 64'd0);
      chk(tick == 1'b0, "rst_tick", 64'(tick), 64'd0);
      chk(running == 1'b0, "rst_running", 64'(running), 64'd0);
      chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
      chk(tick_count == 32'd0, "rst_tick_count", 64'(tick_count), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs();
      chk(cfg_ready == 1'b1, "rst_cfg_ready", 64'(cfg_ready), 64'd1);
      @(negedge clk) reset_n = 1'b1;

      // stop_req in IDLE: ignored, but blocks cfg_ready
      @(negedge clk) stop_req = 1'b1;
      #1 chk(cfg_ready == 1'b0, "idle_stop_ready", 64'(cfg_ready), 64'd0);
      repeat (4) @(posedge clk);
      #2 check_idle("idle_stop");
      @(negedge clk) stop_req = 1'b0;
      #1 chk(cfg_ready == 1'b1, "idle_ready_back", 64'(cfg_ready), 64'd1);

      // Period 0xC34F: seven writes, then stop
      accept(64'h0000_0000_0000_C34F, acc);
      push_prog(64'h0000_0000_0000_C34F, acc);
      prog_timing();
      goto_cyc(acc + 8);
      stop_req = 1'b1;
      push(4'd1, 16'h0008, 1'b0, 0, acc + 9);
      push(4'd0, 16'h0000, 1'b0, 0, acc + 10);
      wait_empty(30, "stop_a_drain");
      check_idle("stop_a");
      stop_req = 1'b0;

      // Period 9: ticks every 10, then irq+stop+cfg in the same RUN cycle
      accept(64'd9, acc);
      chk(tick_count == 32'd0, "tc_after_accept9", 64'(tick_count), 64'd0);
      push_prog(64'd9, acc);
      push_ticks(acc, 9, 1, 4);
      push(4'd1, 16'h0008, 1'b0, 0, acc + 51);
      push(4'd0, 16'h0000, 1'b0, 0, acc + 52);
      prog_timing();
      for (int k = 47; k <= 52; k++) begin
         goto_cyc(acc + k);
         if (k == 47) begin
            chk(tmr_irq == 1'b1, "irq_before_tick4", 64'(tmr_irq), 64'd1);
            stop_req   = 1'b1;
            cfg_valid  = 1'b1;
            cfg_period = 64'd5;
         end
         chk(cfg_ready == 1'b0, "ready_blocked", 64'(cfg_ready), 64'd0);
      end
      wait_empty(40, "combo_drain");
      check_idle("combo");
      stop_req  = 1'b0;
      cfg_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk(cfg_ready == 1'b1, "combo_idle_ready", 64'(cfg_ready), 64'd1);
      chk(tick_count == 32'(exp_tc(4)), "combo_tc_kept", 64'(tick_count), 64'(exp_tc(4)));

      // Period 1 clamped to 4: 100 ticks 5 clocks apart
      accept(64'd1, acc);
      push_prog(64'd4, acc);
      push_ticks(acc, 4, 1, 100);
      prog_timing();
      wait_empty(600, "clamp_drain");

      // Reprogram in RUN to 99, then to 0x1_0000_0000
      accept(64'd99, acc);
      push_prog(64'd99, acc);
      push_ticks(acc, 99, 1, 2);
      prog_timing();
      wait_empty(300, "p99_drain");
      chk(tick_count == 32'(exp_tc(2)), "tc_before_reprog", 64'(tick_count), 64'(exp_tc(2)));
      accept(64'h0000_0001_0000_0000, acc);
      chk(tick_count == 32'd0, "tc_cleared", 64'(tick_count), 64'd0);
      push_prog(64'h0000_0001_0000_0000, acc);
      prog_timing();
      goto_cyc(acc + 8);
      stop_req = 1'b1;
      push(4'd1, 16'h0008, 1'b0, 0, acc + 9);
      push(4'd0, 16'h0000, 1'b0, 0, acc + 10);
      wait_empty(30, "stop_b_drain");
      check_idle("stop_b");
      stop_req = 1'b0;

      // Reset while S_P2 is on the bus
      accept(64'd9, acc);
      push(4'd1, 16'h0008, 1'b0, 0, acc);
      push(4'd0, 16'h0000, 1'b0, 0, acc + 1);
      push(4'd2, 16'h0009, 1'b0, 0, acc + 2);
      push(4'd3, 16'h0000, 1'b0, 0, acc + 3);
      goto_cyc(acc + 4);
      chk(tmr_address == 4'd4, "p2_on_bus", 64'(tmr_address), 64'd4);
      chk(exp_q.size() == 0, "pre_reset_writes", 64'(exp_q.size()), 64'd0);
      reset_n = 1'b0;
      #1 check_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      accept(64'd9, acc);
      push_prog(64'd9, acc);
      push_ticks(acc, 9, 1, 2);
      prog_timing();
      wait_empty(100, "restart_drain");
      stop_req = 1'b1;
      push(4'd1, 16'h0008, 1'b0, 0, -1);
      push(4'd0, 16'h0000, 1'b0, 0, -1);
      wait_empty(30, "stop_c_drain");
      check_idle("stop_c");
      stop_req = 1'b0;
      repeat (5) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
